// File: rtl/imm_buffer_if.sv
// Dispatch/issue/commit bundle for the immediate buffer.
// The master side is the core pipeline; the slave side is imm_buffer.
interface imm_buffer_if #(
  parameter int DEPTH        = 32,
  parameter int ENQ_WIDTH    = 4,
  parameter int READ_PORTS   = 2,
  parameter int COMMIT_WIDTH = 4,
  parameter int IDX_W        = $clog2(DEPTH) + 1
);
  logic [ENQ_WIDTH-1:0]                  i_enq_req;
  logic [ENQ_WIDTH-1:0][19:0]            i_enq_imm20;
  logic                                  o_can_enq;
  logic [ENQ_WIDTH-1:0][IDX_W-1:0]       o_alloc_idx;
  logic [READ_PORTS-1:0][IDX_W-1:0]      i_read_idx;
  logic [READ_PORTS-1:0][19:0]           o_read_imm20;
  logic [COMMIT_WIDTH-1:0]               i_commit_vld;
  logic                                  i_squash;
  logic [$clog2(DEPTH):0]                o_count;

  modport master (
    output i_enq_req, i_enq_imm20, i_read_idx, i_commit_vld, i_squash,
    input  o_can_enq, o_alloc_idx, o_read_imm20, o_count
  );

  modport slave (
    input  i_enq_req, i_enq_imm20, i_read_idx, i_commit_vld, i_squash,
    output o_can_enq, o_alloc_idx, o_read_imm20, o_count
  );
endinterface

// File: rtl/imm_buffer.sv
// Circular imm20 store indexed by {wrap, ptr}; dispatch allocates in lane order,
// issue reads one cycle ahead of execute, commit frees in order, squash drops the rest.
module imm_buffer #(
  parameter int DEPTH        = 32,
  parameter int ENQ_WIDTH    = 4,
  parameter int READ_PORTS   = 2,
  parameter int COMMIT_WIDTH = 4,
  parameter int IDX_W        = $clog2(DEPTH) + 1
) (
  input  logic       clk,
  input  logic       rst,
  imm_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  typedef logic [IDX_W-1:0] idx_t;

  idx_t        head_reg, head_next;
  idx_t        tail_reg, tail_next;
  idx_t        count_w;
  idx_t        enq_n, commit_n;
  idx_t        enq_offset [ENQ_WIDTH];
  idx_t        alloc_idx  [ENQ_WIDTH];
  logic        can_enq;
  logic        enq_fire;
  logic [19:0] mem_reg       [DEPTH];
  logic [19:0] read_data_reg [READ_PORTS];

  // Wrap flag in the MSB makes the plain difference the occupancy, full included.
  assign count_w  = tail_reg - head_reg;
  assign can_enq  = rst && (count_w <= idx_t'(DEPTH - ENQ_WIDTH));
  assign enq_fire = can_enq && (|bus.i_enq_req) && !bus.i_squash;

  always_comb begin
    enq_n = '0;
    for (int k = 0; k < ENQ_WIDTH; k++) begin
      enq_offset[k] = enq_n;
      enq_n = enq_n + idx_t'(bus.i_enq_req[k]);
    end
  end

  always_comb begin
    commit_n = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      commit_n = commit_n + idx_t'(bus.i_commit_vld[k]);
    end
  end

  for (genvar gi = 0; gi < ENQ_WIDTH; gi++) begin : g_alloc
    assign alloc_idx[gi]       = tail_reg + enq_offset[gi];
    assign bus.o_alloc_idx[gi] = alloc_idx[gi];
  end

  // Commits still retire on a squash cycle, so the squashed tail lands on the post-commit head.
  always_comb begin
    head_next = head_reg + commit_n;
    tail_next = tail_reg;
    if (bus.i_squash) begin
      tail_next = head_next;
    end else if (enq_fire) begin
      tail_next = tail_reg + enq_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      head_reg <= head_next;
      tail_reg <= tail_next;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int k = 0; k < ENQ_WIDTH; k++) begin
        if (bus.i_enq_req[k]) begin
          mem_reg[alloc_idx[k][PTR_W-1:0]] <= bus.i_enq_imm20[k];
        end
      end
    end
  end

  // Registered read sees pre-write contents on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int p = 0; p < READ_PORTS; p++) begin
        read_data_reg[p] <= '0;
      end
    end else begin
      for (int p = 0; p < READ_PORTS; p++) begin
        read_data_reg[p] <= mem_reg[bus.i_read_idx[p][PTR_W-1:0]];
      end
    end
  end

  for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_read_out
    assign bus.o_read_imm20[gi] = read_data_reg[gi];
  end

  assign bus.o_can_enq = can_enq;
  assign bus.o_count   = rst ? count_w : '0;

`ifndef SYNTHESIS
  a_commit_le_count: assert property (@(posedge clk) disable iff (!rst)
    commit_n <= count_w);

  a_enq_when_allowed: assert property (@(posedge clk) disable iff (!rst)
    (|bus.i_enq_req) |-> can_enq);

  for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_read_chk
    a_read_in_window: assert property (@(posedge clk) disable iff (!rst)
      (count_w != '0) |-> (idx_t'(bus.i_read_idx[gi] - head_reg) < count_w));
  end
`endif

endmodule

// File: tb/tb_imm_buffer.sv
// Bench for imm_buffer: vector table plus hand sequences for full, wrap, squash,
// and a constrained-random tail, all scored against a pointer/data model.
module tb_imm_buffer;
  localparam int DEPTH        = 32;
  localparam int ENQ_WIDTH    = 4;
  localparam int READ_PORTS   = 2;
  localparam int COMMIT_WIDTH = 4;
  localparam int IDX_W        = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  imm_buffer_if #(.DEPTH(DEPTH), .ENQ_WIDTH(ENQ_WIDTH), .READ_PORTS(READ_PORTS),
                  .COMMIT_WIDTH(COMMIT_WIDTH), .IDX_W(IDX_W)) bus ();

  imm_buffer #(.DEPTH(DEPTH), .ENQ_WIDTH(ENQ_WIDTH), .READ_PORTS(READ_PORTS),
               .COMMIT_WIDTH(COMMIT_WIDTH), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          head_m = 0;
  int          tail_m = 0;
  logic [19:0] mem_m [DEPTH];

  typedef struct {
    int          port;
    logic [19:0] data;
  } rd_exp_t;
  rd_exp_t sb_q [$];

  typedef struct {
    logic [3:0]       req;
    logic [3:0][19:0] imm;
    logic [3:0]       cv;
    logic             sq;
    int               r0;
    int               exp_count;
    logic             exp_can;
  } vec_t;

  function automatic int count_m();
    return (tail_m - head_m) & 63;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; called right after an active edge (+1).
  task automatic do_cycle(input logic [3:0] req, input logic [3:0][19:0] imm,
                          input logic [3:0] cv, input logic sq, input int r0, input int r1);
    int      cnt;
    int      pre;
    logic    can;
    int      rds [2];
    rd_exp_t e;
    rds[0] = r0;
    rds[1] = r1;
    bus.i_enq_req    = req;
    bus.i_enq_imm20  = imm;
    bus.i_commit_vld = cv;
    bus.i_squash     = sq;
    for (int p = 0; p < READ_PORTS; p++) bus.i_read_idx[p] = 6'(rds[p]);
    #1;
    cnt = count_m();
    can = (cnt <= DEPTH - ENQ_WIDTH);
    chk("can_enq", 32'(bus.o_can_enq), 32'(can));
    pre = 0;
    for (int k = 0; k < ENQ_WIDTH; k++) begin
      if (req[k]) begin
        chk("alloc_idx", 32'(bus.o_alloc_idx[k]), 32'((tail_m + pre) & 63));
        pre++;
      end
    end
    for (int p = 0; p < READ_PORTS; p++) begin
      if (((rds[p] - head_m) & 63) < cnt) begin
        e.port = p;
        e.data = mem_m[rds[p] & 31];
        sb_q.push_back(e);
      end
    end
    if (can && (req != 4'b0) && !sq) begin
      pre = 0;
      for (int k = 0; k < ENQ_WIDTH; k++) begin
        if (req[k]) begin
          mem_m[(tail_m + pre) & 31] = imm[k];
          pre++;
        end
      end
      tail_m = (tail_m + pre) & 63;
    end
    head_m = (head_m + $countones(cv)) & 63;
    if (sq) tail_m = head_m;
    @(posedge clk);
    #1;
    chk("count", 32'(bus.o_count), 32'(count_m()));
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("read_imm20", 32'(bus.o_read_imm20[e.port]), 32'(e.data));
    end
    $display("[TB] cycle req=%b cv=%b sq=%b rd=%0d/%0d count=%0d can=%b",
             req, cv, sq, r0, r1, bus.o_count, bus.o_can_enq);
  endtask

  task automatic enq(input logic [3:0] req, input logic [3:0][19:0] imm);
    do_cycle(req, imm, 4'b0, 1'b0, head_m, head_m);
  endtask

  task automatic commit(input logic [3:0] cv);
    do_cycle(4'b0, '0, cv, 1'b0, head_m, head_m);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    bus.i_enq_req    = '0;
    bus.i_enq_imm20  = '0;
    bus.i_commit_vld = '0;
    bus.i_squash     = 1'b0;
    bus.i_read_idx   = '0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rst_can_enq", 32'(bus.o_can_enq), 32'd0);
      @(posedge clk);
      #1;
      chk("rst_count", 32'(bus.o_count), 32'd0);
      chk("rst_read0", 32'(bus.o_read_imm20[0]), 32'd0);
      chk("rst_read1", 32'(bus.o_read_imm20[1]), 32'd0);
      $display("[TB] reset cycle %0d", i);
    end
    head_m = 0;
    tail_m = 0;
    sb_q.delete();
    rst = 1'b1;
    #1;
    chk("post_rst_can_enq", 32'(bus.o_can_enq), 32'd1);
    chk("post_rst_count", 32'(bus.o_count), 32'd0);
  endtask

  vec_t vecs [6];

  initial begin
    logic [3:0]  rq;
    logic [3:0]  cv;
    logic [3:0][19:0] im;
    int          c;

    vecs[0] = '{4'b1010, {20'h33333, 20'h0, 20'h11111, 20'h0}, 4'b0000, 1'b0, 0, 2, 1'b1};
    vecs[1] = '{4'b0000, '0, 4'b0000, 1'b0, 1, 2, 1'b1};
    vecs[2] = '{4'b0111, {20'h0, 20'hA0002, 20'hA0001, 20'hA0000}, 4'b0000, 1'b0, 0, 5, 1'b1};
    vecs[3] = '{4'b0111, {20'h0, 20'hB0002, 20'hB0001, 20'hB0000}, 4'b0011, 1'b0, 2, 6, 1'b1};
    vecs[4] = '{4'b0000, '0, 4'b1111, 1'b0, 3, 2, 1'b1};
    vecs[5] = '{4'b0000, '0, 4'b0101, 1'b0, 6, 0, 1'b1};

    // Reset held two cycles, then idle.
    do_reset(2);

    // Sparse lanes get compacted indices 0 and 1.
    bus.i_enq_req = 4'b1010;
    #1;
    chk("sparse_alloc1", 32'(bus.o_alloc_idx[1]), 32'd0);
    chk("sparse_alloc3", 32'(bus.o_alloc_idx[3]), 32'd1);

    for (int i = 0; i < 6; i++) begin
      chk("vec_can_enq", 32'(bus.o_can_enq), 32'(vecs[i].exp_can));
      do_cycle(vecs[i].req, vecs[i].imm, vecs[i].cv, vecs[i].sq, vecs[i].r0, head_m);
      chk("vec_count", 32'(bus.o_count), 32'(vecs[i].exp_count));
      if (i == 1) chk("sparse_read", 32'(bus.o_read_imm20[0]), 32'h33333);
    end

    // Full back-pressure.
    do_reset(1);
    for (int i = 0; i < 7; i++) begin
      enq(4'b1111, {20'(i * 16 + 3), 20'(i * 16 + 2), 20'(i * 16 + 1), 20'(i * 16)});
    end
    chk("full28_count", 32'(bus.o_count), 32'd28);
    chk("full28_can", 32'(bus.o_can_enq), 32'd1);
    enq(4'b1111, {20'hF0003, 20'hF0002, 20'hF0001, 20'hF0000});
    chk("full32_count", 32'(bus.o_count), 32'd32);
    chk("full32_can", 32'(bus.o_can_enq), 32'd0);
    do_cycle(4'b0, '0, 4'b0, 1'b0, 31, 5);
    chk("full_read31", 32'(bus.o_read_imm20[0]), 32'hF0003);
    commit(4'b1111);
    chk("full_commit_can", 32'(bus.o_can_enq), 32'd1);
    chk("full_commit_count", 32'(bus.o_count), 32'd28);

    // Wrap across the flag boundary.
    do_reset(1);
    for (int i = 0; i < 7; i++) enq(4'b1111, {20'(i + 300), 20'(i + 200), 20'(i + 100), 20'(i)});
    enq(4'b0011, {20'h0, 20'h0, 20'h0E001, 20'h0E000});
    chk("wrap_fill30", 32'(bus.o_count), 32'd30);
    for (int i = 0; i < 7; i++) commit(4'b1111);
    commit(4'b0011);
    chk("wrap_empty", 32'(bus.o_count), 32'd0);
    bus.i_enq_req = 4'b1111;
    #1;
    chk("wrap_alloc0", 32'(bus.o_alloc_idx[0]), 32'd30);
    chk("wrap_alloc1", 32'(bus.o_alloc_idx[1]), 32'd31);
    chk("wrap_alloc2", 32'(bus.o_alloc_idx[2]), 32'd32);
    chk("wrap_alloc3", 32'(bus.o_alloc_idx[3]), 32'd33);
    enq(4'b1111, {20'hD0003, 20'hD0002, 20'hD0001, 20'hD0000});
    do_cycle(4'b0, '0, 4'b0, 1'b0, 33, 30);
    chk("wrap_read33", 32'(bus.o_read_imm20[0]), 32'hD0003);
    chk("wrap_read30", 32'(bus.o_read_imm20[1]), 32'hD0000);

    // Squash with same-cycle commit and enqueue.
    do_reset(1);
    enq(4'b1111, {20'h1, 20'h2, 20'h3, 20'h4});
    enq(4'b1111, {20'h5, 20'h6, 20'h7, 20'h8});
    enq(4'b0011, {20'h0, 20'h0, 20'h9, 20'hA});
    chk("sq_count10", 32'(bus.o_count), 32'd10);
    do_cycle(4'b1111, {20'hC3, 20'hC2, 20'hC1, 20'hC0}, 4'b0011, 1'b1, head_m, head_m);
    chk("sq_count0", 32'(bus.o_count), 32'd0);
    bus.i_enq_req = 4'b0001;
    bus.i_squash  = 1'b0;
    bus.i_commit_vld = 4'b0;
    #1;
    chk("sq_tail2", 32'(bus.o_alloc_idx[0]), 32'd2);
    enq(4'b0001, {20'h0, 20'h0, 20'h0, 20'h5A5A5});
    do_cycle(4'b0, '0, 4'b0, 1'b0, 2, 2);
    chk("sq_read2", 32'(bus.o_read_imm20[0]), 32'h5A5A5);

    // Constrained-random legal traffic.
    for (int i = 0; i < 80; i++) begin
      c  = count_m();
      rq = (c <= DEPTH - ENQ_WIDTH) ? 4'($urandom) : 4'b0;
      cv = 4'($urandom);
      for (int k = 3; k >= 0; k--) begin
        if ($countones(cv) > c) cv[k] = 1'b0;
      end
      for (int k = 0; k < 4; k++) im[k] = 20'($urandom);
      do_cycle(rq, im, cv, ($urandom_range(0, 15) == 0),
               (c > 0) ? head_m + int'($urandom_range(0, c - 1)) : head_m,
               (c > 0) ? head_m + int'($urandom_range(0, c - 1)) : head_m);
    end

    // Reset mid-operation clears pointers and the read register.
    enq(4'b1111, {20'h77777, 20'h66666, 20'h55555, 20'h44444});
    do_reset(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/imm_buffer.md
Name: imm_buffer

Overview:
- Circular immediate store indexed by irobIdx_t (immB_idx). Removes the 20-bit imm20 from RS entries.
- Dispatch writes the imm20 of each immOp instruction and receives an allocated index. RS/issue reads by index one cycle before execute. Commit frees entries in order.
- Squash (raised only at branch retire) releases every uncommitted entry.

Parameters:
DEPTH, 32, number of entries (power of two)
ENQ_WIDTH, 4, dispatch write lanes per cycle
READ_PORTS, 2, issue read ports (one per immOp FU)
COMMIT_WIDTH, 4, commit lanes per cycle
IDX_W, $clog2(DEPTH)+1, index width: {wrap flag, ptr}; equals irobIdx_t

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (asserted when 0)
i_enq_req  in  ENQ_WIDTH  lane k carries an immOp instruction
i_enq_imm20  in  ENQ_WIDTH x 20  imm20 per lane
o_can_enq  out  1  buffer accepts a full dispatch group this cycle
o_alloc_idx  out  ENQ_WIDTH x IDX_W  allocated index per lane (valid where i_enq_req=1)
i_read_idx  in  READ_PORTS x IDX_W  issue read index
o_read_imm20  out  READ_PORTS x 20  registered read data
i_commit_vld  in  COMMIT_WIDTH  committed instruction k used an imm entry
i_squash  in  1  flush all uncommitted entries
o_count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- State: head and tail pointers, each IDX_W bits (MSB = wrap flag); count = tail - head mod 2*DEPTH; data array DEPTH x 20 (not reset).
- Reset (rst=0 at posedge):
  - head=tail=0, o_read_imm20=0.
  - o_can_enq is forced 0 while rst=0, o_count=0.
- o_can_enq (combinational): count <= DEPTH-ENQ_WIDTH, using current-cycle count only. Frees in the same cycle are not credited. Dispatch enqueues only when o_can_enq=1; the check is all-or-nothing per group.
- Allocation is compacted and in lane order:
  - o_alloc_idx[k] = tail + popcount(i_enq_req[k-1:0]).
  - Lanes with i_enq_req=0 consume no entry, and their o_alloc_idx is don't-care.
- Enqueue fire = o_can_enq & |i_enq_req & !i_squash.
  - On fire, data[ptr(o_alloc_idx[k])] <= i_enq_imm20[k] for requesting lanes.
  - tail <= tail + popcount(i_enq_req).
- Read:
  - o_read_imm20[p] <= data[ptr(i_read_idx[p])] every cycle, giving 1-cycle latency. This matches RS select(p0) -> deq(p1).
  - Read-during-write to the same entry returns old data. RS never issues an instruction in its enqueue cycle.
  - The wrap flag of i_read_idx is ignored for addressing.
- Commit: head <= head + popcount(i_commit_vld). Lanes may be sparse. Commit is applied even when i_squash=1 in the same cycle.
- Squash: tail <= head_next, where head_next is head after that cycle's commits. Count becomes 0 and the enqueue in that cycle is dropped. Squash has priority over enqueue.
- Simultaneous enqueue and commit: both pointers advance. count_next = count + enq_n - commit_n.
- Wrap-around: pointer arithmetic is modulo 2*DEPTH. The flag toggles when ptr crosses DEPTH-1 -> 0. Full = flags differ and ptrs equal (count=DEPTH).
- Illegal, checked by assertions in simulation:
  - popcount(i_commit_vld) > count.
  - Enqueue while o_can_enq=0.
  - Read of an index not in [head, tail).
- Reset mid-operation: all pointers are cleared at the next posedge. Any in-flight read result is replaced by 0.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then rst=1 -> o_count=0 and o_can_enq=1. o_can_enq=0 and o_read_imm20=0 during reset.
- Sparse enqueue: i_enq_req=4'b1010 with imm 0x11111 (lane1) and 0x33333 (lane3) -> o_alloc_idx[1]=0 and [3]=1; o_count=2 next cycle. Reading idx 1 returns 0x33333 one cycle later.
- Full back-pressure: enqueue 4 per cycle for 7 cycles -> count=28, o_can_enq=1. One more group -> count=32, o_can_enq=0, tail=6'b100000. Commit 4 -> o_can_enq=1 next cycle.
- Wrap: fill to 30, commit 30, enqueue 4 -> indices 30,31,32,33 (flag set, ptr 0,1). Reading idx 33 returns lane3 data.
- Squash with same-cycle commit and enqueue: count=10, commit_vld=4'b0011, enq 4, squash=1 -> next head=2, tail=2, count=0, and the enqueue is ignored.
- Same-cycle enqueue and commit: count=5, enq 3, commit 2 -> count=6. o_can_enq is based on 5, so it stays 1.
